// File: rtl/mem_wbuf_ram.sv
// Single-port-address RAM with a one-entry write buffer and a post-reset
// zero-fill sweep. The array has one synchronous write port and one
// synchronous read port, so it maps onto a single-clock block RAM.
// A write is parked in the buffer for one cycle before it reaches the array.
// A read of the buffered address is served from the buffer, so written data
// is readable on the very next cycle.
module mem_wbuf_ram #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 9,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;

  // Write buffer: holds the most recently accepted write until the next edge.
  logic                wb_vld_reg;
  logic [ADDR_W-1:0]   wb_addr_reg;
  logic [DATA_W-1:0]   wb_data_reg;

  // Storage and its single write port.
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Read pipeline: raw RAM output plus the forwarding decision taken at the
  // read edge; the final mux picks between them.
  logic [DATA_W-1:0]   ram_q_reg;
  logic                fwd_reg;
  logic [DATA_W-1:0]   fwd_data_reg;
  logic                rvalid_reg;

  logic                accept_we;
  logic                accept_re;
  logic                wb_hit;

  assign accept_we = (state_reg == READY) && i_we;
  assign accept_re = (state_reg == READY) && i_re;
  assign wb_hit    = wb_vld_reg && (wb_addr_reg == i_addr);

  // State and sweep counter; reset restarts the sweep from address 0.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg <= RST_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state and array write-port selection: sweep zeros while clearing,
  // otherwise commit the buffered write.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_we     = 1'b0;
    mem_waddr  = wb_addr_reg;
    mem_wdata  = wb_data_reg;
    o_busy     = 1'b0;
    case (state_reg)
      CLEAR: begin
        o_busy    = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        // The counter parks on the last address so it never starts a second pass.
        if (cnt_reg == {ADDR_W{1'b1}}) begin
          state_next = READY;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      READY: begin
        mem_we = wb_vld_reg;
      end
      default: begin
        state_next = RST_STATE;
      end
    endcase
  end

  // Write buffer: load on an accepted write, otherwise drain; reset drops any
  // pending write so it never reaches the array.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wb_vld_reg  <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_vld_reg <= accept_we;
      if (accept_we) begin
        wb_addr_reg <= i_addr;
        wb_data_reg <= i_wdata;
      end
    end
  end

  // Block RAM body: no reset, one write port, one registered read port.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (accept_re) begin
      ram_q_reg <= mem[i_addr];
    end
  end

  // Read control: remember whether this read hits the buffer and what it holds.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rvalid_reg   <= 1'b0;
      fwd_reg      <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      rvalid_reg   <= accept_re;
      fwd_reg      <= accept_re && wb_hit;
      fwd_data_reg <= wb_data_reg;
    end
  end

  assign o_rvalid = rvalid_reg;
  assign o_rdata  = rvalid_reg ? (fwd_reg ? fwd_data_reg : ram_q_reg) : '0;

endmodule

// File: tb/tb_mem_wbuf_ram.sv
// Directed bench for mem_wbuf_ram with default parameters (8-bit data,
// 512 words, clear-on-reset enabled).
module tb_mem_wbuf_ram;

  logic       i_clk;
  logic       i_nrst;
  logic [8:0] i_addr;
  logic       i_we;
  logic [7:0] i_wdata;
  logic       i_re;
  logic [7:0] o_rdata;
  logic       o_rvalid;
  logic       o_busy;

  int err_cnt;
  int chk_cnt;

  mem_wbuf_ram dut (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_addr   (i_addr),
    .i_we     (i_we),
    .i_wdata  (i_wdata),
    .i_re     (i_re),
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_we    = 1'b0;
    i_re    = 1'b0;
    i_wdata = 8'h00;
  endtask

  // Count edges until o_busy falls, bounded.
  task automatic sweep_len(output int n);
    n = 0;
    while (o_busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  int n;
  int rv_seen;

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    i_nrst  = 1'b0;
    i_addr  = '0;
    idle();

    // Reset state
    tick();
    tick();
    check("rst_rdata", {24'd0, o_rdata}, 32'h0);
    check("rst_rvalid", {31'd0, o_rvalid}, 32'h0);
    check("rst_busy", {31'd0, o_busy}, 32'h1);

    // Release; attempt a read and a write of addr 5 for the whole sweep
    i_nrst  = 1'b1;
    i_addr  = 9'h005;
    i_re    = 1'b1;
    i_we    = 1'b1;
    i_wdata = 8'h77;
    n       = 0;
    rv_seen = 0;
    while (o_busy && n < 2000) begin
      tick();
      n++;
      if (o_rvalid) rv_seen++;
    end
    idle();
    check("sweep_len", n, 512);
    check("busy_rvalid_seen", rv_seen, 0);

    // Read top address after sweep
    i_addr = 9'h1FF;
    i_re   = 1'b1;
    tick();
    check("rd_1ff_rvalid", {31'd0, o_rvalid}, 32'h1);
    check("rd_1ff_data", {24'd0, o_rdata}, 32'h0);
    idle();
    tick();
    check("noread_rvalid", {31'd0, o_rvalid}, 32'h0);
    check("noread_rdata", {24'd0, o_rdata}, 32'h0);
    i_addr = 9'h005;
    i_re   = 1'b1;
    tick();
    check("rd_005_data", {24'd0, o_rdata}, 32'h0);
    idle();

    // Write then immediate read (forwarded), later read (array)
    i_addr  = 9'h010;
    i_we    = 1'b1;
    i_wdata = 8'hA5;
    tick();
    idle();
    i_re = 1'b1;
    tick();
    check("fwd_010", {24'd0, o_rdata}, 32'hA5);
    idle();
    tick();
    tick();
    i_re = 1'b1;
    tick();
    check("arr_010", {24'd0, o_rdata}, 32'hA5);
    idle();

    // Read-before-write at 0x020
    i_addr  = 9'h020;
    i_we    = 1'b1;
    i_wdata = 8'h11;
    tick();
    idle();
    tick();
    i_we    = 1'b1;
    i_re    = 1'b1;
    i_wdata = 8'h22;
    tick();
    check("rbw_020_old", {24'd0, o_rdata}, 32'h11);
    idle();
    i_re = 1'b1;
    tick();
    check("rbw_020_new", {24'd0, o_rdata}, 32'h22);
    idle();

    // Back-to-back writes 0..7, then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      i_addr  = 9'(i);
      i_we    = 1'b1;
      i_wdata = 8'(i + 1);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      i_addr = 9'(i);
      i_re   = 1'b1;
      tick();
      check($sformatf("b2b_rv_%0d", i), {31'd0, o_rvalid}, 32'h1);
      check($sformatf("b2b_rd_%0d", i), {24'd0, o_rdata}, 32'(i + 1));
    end
    idle();

    // Preload 0x030, then write 0x5A with a same-cycle read, then reset
    i_addr  = 9'h030;
    i_we    = 1'b1;
    i_wdata = 8'h3C;
    tick();
    idle();
    tick();
    i_we    = 1'b1;
    i_re    = 1'b1;
    i_wdata = 8'h5A;
    tick();
    check("rbw_030_old", {24'd0, o_rdata}, 32'h3C);
    i_nrst = 1'b0;
    idle();
    #1;
    check("async_rst_rdata", {24'd0, o_rdata}, 32'h0);
    check("async_rst_rvalid", {31'd0, o_rvalid}, 32'h0);
    check("async_rst_busy", {31'd0, o_busy}, 32'h1);
    tick();
    tick();

    // Partial sweep, reset at cycle 100, full sweep afterwards
    i_nrst = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check("mid_sweep_busy", {31'd0, o_busy}, 32'h1);
    i_nrst = 1'b0;
    tick();
    i_nrst = 1'b1;
    sweep_len(n);
    check("resweep_len", n, 512);

    i_addr = 9'h030;
    i_re   = 1'b1;
    tick();
    check("post_rst_030_rv", {31'd0, o_rvalid}, 32'h1);
    check("post_rst_030", {24'd0, o_rdata}, 32'h0);
    i_addr = 9'h010;
    tick();
    check("post_rst_010", {24'd0, o_rdata}, 32'h0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_wbuf_ram.md
MEM_WBUF_RAM -- requirements
Module: mem_wbuf_ram

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter ADDR_W, default 9: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole array after reset; 0 = no zero-fill, contents undefined.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_nrst  input  1  asynchronous, active-low reset.
REQ-006 i_addr  input  ADDR_W  shared read/write address.
REQ-007 i_we  input  1  write request, sampled at the rising edge.
REQ-008 i_wdata  input  DATA_W  write data.
REQ-009 i_re  input  1  read request, sampled at the rising edge.
REQ-010 o_rdata  output  DATA_W  registered read data.
REQ-011 o_rvalid  output  1  o_rdata holds the result of a read accepted on the previous edge.
REQ-012 o_busy  output  1  clear sweep in progress; requests ignored.

Function
REQ-013 State machine SHALL have states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-014 CLEAR SHALL write 0 to address cnt each cycle, cnt counting 0..DEPTH-1, then move to READY; the sweep lasts exactly DEPTH cycles.
REQ-015 o_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-016 i_we and i_re in CLEAR SHALL be dropped: no array update, o_rvalid=0.
REQ-017 Accepted write (READY, i_we=1) SHALL load a write buffer (wb_vld, wb_addr, wb_data) at edge N; the array SHALL commit it at edge N+1.
REQ-018 Back-to-back writes SHALL each be accepted every cycle: edge N+1 commits the old buffer and loads the new one; no write lost.
REQ-019 wb_vld SHALL clear at the commit edge unless a new write loads the buffer on the same edge.
REQ-020 Accepted read (READY, i_re=1) at edge N SHALL drive o_rdata and o_rvalid=1 after edge N, held for one cycle.
REQ-021 Read-data source SHALL be wb_data if wb_vld=1 and wb_addr=i_addr at edge N, else array[i_addr].
REQ-022 i_we=1 and i_re=1 together at one address SHALL return the prior contents (read-before-write); the new data becomes readable from the next cycle.
REQ-023 Write then read of the same address on the next cycle SHALL return the new data via REQ-021.
REQ-024 No accepted read SHALL give o_rdata=0 and o_rvalid=0 on the next cycle.
REQ-025 Address arithmetic SHALL be ADDR_W bits unsigned; cnt SHALL stop at DEPTH-1 with no wrap into a second sweep.
REQ-026 Array SHALL be inferable as single-clock block RAM: one read port, one write port, both synchronous to i_clk.

Reset
REQ-027 Asserting i_nrst SHALL force o_rdata=0, o_rvalid=0, wb_vld=0, cnt=0, and o_busy=CLEAR_ON_RESET.
REQ-028 A write still in the buffer at reset SHALL be discarded, not committed.
REQ-029 Reset during CLEAR SHALL restart the sweep from address 0 after release.
REQ-030 Array contents SHALL not be reset asynchronously; only the post-reset sweep clears them.

Verification
REQ-031 Reset release, defaults: o_busy=1 for exactly 512 cycles, then 0; read of addr 0x1FF returns 0x00, o_rvalid=1.
REQ-032 i_re at addr 5 while o_busy=1 -> o_rvalid stays 0; no write to addr 5 occurs.
REQ-033 Write 0xA5 to 0x010, read 0x010 on the next cycle -> o_rdata=0xA5 (forwarded); read again 3 cycles later -> 0xA5 (from array).
REQ-034 Array 0x020=0x11; write 0x22 to 0x020 with i_re=1 in the same cycle -> o_rdata=0x11; next-cycle read -> 0x22.
REQ-035 Writes 0x01..0x08 to addresses 0..7 on consecutive cycles, then reads 0..7 -> 0x01..0x08 in order, o_rvalid=1 each cycle.
REQ-036 Reset asserted one cycle after a write to 0x030, then sweep completes -> read 0x030 returns 0x00; reset at sweep cycle 100 -> o_busy=1 for a full 512 cycles after release.
